execute_port2_wb_queue: RTL and testbench
=========================================

EXECUTE_PORT2_WB_QUEUE -- requirements
Module: execute_port2_wb_queue

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 SHALL have parameter DEPTH, default 4, number of queue entries; power of 2, minimum 4.
REQ-003 SHALL have parameter LOCK_MARGIN, default 2, free-slot count at or below which upstream is locked.
REQ-004 SHALL have port iCLOCK, input, 1, clock.
REQ-005 SHALL have port iRESET, input, 1, async active-high reset.
REQ-006 SHALL have port iFREE_EX, input, 1, synchronous pipeline flush.
REQ-007 SHALL have port iEX_ALU2_VALID, input, 1, ALU2 result valid; one push per cycle.
REQ-008 SHALL have port iEX_ALU2_PAYLOAD, input, 61, packed ALU2 result (layout in REQ-016).
REQ-009 SHALL have port iSCHE2_READY, input, 1, scheduler2 accepts the head entry.
REQ-010 SHALL have port oEX_ALU2_LOCK, output, 1, backpressure to ALU2 issue.
REQ-011 SHALL have port oSCHE2_VALID, output, 1, head entry valid.
REQ-012 SHALL have port oSCHE2_PAYLOAD, output, 61, head entry payload (same layout).
REQ-013 SHALL have port oSCHE1_VALID, output, 1, one-cycle commit notification.
REQ-014 SHALL have port oSCHE1_COMMIT_TAG, output, 6, commit tag of the retired entry.
REQ-015 SHALL have ports oCOUNT, output, log2(DEPTH)+1, occupancy; and oOVERFLOW, output, 1, sticky dropped-push error.

Function
REQ-016 SHALL use this payload layout: [60:55] commit_tag, [54] sysreg, [53:49] logic_dest, [48:43] dest regname, [42] writeback, [41:10] data, [9:5] flags {SF,OF,CF,PF,ZF}, [4] flags_writeback, [3:0] flags regname; the payload SHALL pass through unmodified.
REQ-017 SHALL be a registered FIFO with read/write pointers of log2(DEPTH)+1 bits; full = MSBs differ and LSBs are equal; empty = pointers are equal; pointers wrap modulo 2*DEPTH.
REQ-018 SHALL push when iEX_ALU2_VALID=1, subject to REQ-021 and REQ-022; a push in cycle N SHALL appear at the head with oSCHE2_VALID=1 no earlier than cycle N+1. There is no bypass.
REQ-019 SHALL pop when oSCHE2_VALID=1 and iSCHE2_READY=1; the head payload and oSCHE2_VALID SHALL hold stable while iSCHE2_READY=0.
REQ-020 SHALL drive oSCHE1_VALID=1 and oSCHE1_COMMIT_TAG=popped commit_tag in cycle N+1 for a pop in cycle N. With no pop, oSCHE1_VALID=0 and the tag holds its last value.
REQ-021 SHALL accept a push while full only if a pop occurs in the same cycle; count is then unchanged.
REQ-022 SHALL drop a push while full with no pop, and set oOVERFLOW=1 until reset; pointers and contents are unchanged.
REQ-023 SHALL drive oEX_ALU2_LOCK=1, registered, when (DEPTH - next count) <= LOCK_MARGIN. The margin covers the 2-cycle upstream latency.
REQ-024 SHALL, on iFREE_EX=1, in the next cycle:
  - clear both pointers, count, oSCHE2_VALID, oSCHE1_VALID and oEX_ALU2_LOCK;
  - ignore a same-cycle push (no overflow) and a same-cycle pop (no oSCHE1 pulse);
  - leave oOVERFLOW unchanged.
REQ-025 SHALL apply simultaneous push and pop on a non-full, non-empty queue in one cycle; count is unchanged.
REQ-026 SHALL accept a push to an empty queue while iSCHE2_READY=1; the entry is popped no earlier than the following cycle.

Reset
REQ-027 SHALL, while iRESET=1, force pointers=0, oCOUNT=0, oSCHE2_VALID=0, oSCHE1_VALID=0, oSCHE1_COMMIT_TAG=0, oEX_ALU2_LOCK=0, oOVERFLOW=0 and oSCHE2_PAYLOAD=0; storage contents need not reset.
REQ-028 SHALL discard any in-flight entries on reset asserted mid-operation; the first push after release is at entry 0.

Verification
REQ-029 SHALL cover single pass: push tag 0x05 with data 0x12345678 and iSCHE2_READY=1 -> oSCHE2_VALID the next cycle with identical payload; oSCHE1_VALID pulses one cycle later with tag 0x05.
REQ-030 SHALL cover fill/lock: iSCHE2_READY=0, push tags 1,2,3,4 -> oEX_ALU2_LOCK=1 after the 2nd push, oCOUNT=4, head tag=1.
REQ-031 SHALL cover overflow: full queue plus push of tag 9 with no pop -> oOVERFLOW=1, oCOUNT stays 4, tag 9 is never emitted.
REQ-032 SHALL cover full push+pop: full queue, iSCHE2_READY=1, push tag 7 -> oCOUNT stays 4, no overflow, tag 7 is emitted after tags 2,3,4.
REQ-033 SHALL cover flush: 3 entries, then iFREE_EX=1 with a push of tag 8 -> next cycle oCOUNT=0, oSCHE2_VALID=0, no oSCHE1 pulse, tag 8 is never emitted.
REQ-034 SHALL cover reset mid-stream: assert iRESET with 2 entries queued -> all outputs return to 0 immediately (asynchronously); after release, push tag 0x3F -> emitted alone.

Source files
------------

// File: rtl/execute_port2_wb_queue.sv
// Write-back queue between the ALU2 execute port and scheduler2: registered FIFO
// with occupancy-based issue lock, one-cycle commit notification and sticky overflow flag.
module execute_port2_wb_queue #(
    parameter int DEPTH       = 4,
    parameter int LOCK_MARGIN = 2
) (
    input  logic                      iCLOCK,
    input  logic                      iRESET,
    input  logic                      iFREE_EX,
    input  logic                      iEX_ALU2_VALID,
    input  logic [60:0]               iEX_ALU2_PAYLOAD,
    input  logic                      iSCHE2_READY,
    output logic                      oEX_ALU2_LOCK,
    output logic                      oSCHE2_VALID,
    output logic [60:0]               oSCHE2_PAYLOAD,
    output logic                      oSCHE1_VALID,
    output logic [5:0]                oSCHE1_COMMIT_TAG,
    output logic [$clog2(DEPTH):0]    oCOUNT,
    output logic                      oOVERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [60:0]    mem [DEPTH];

    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic           sche1_valid_q, sche1_valid_d;
    logic [5:0]     sche1_tag_q, sche1_tag_d;
    logic           lock_q, lock_d;
    logic           overflow_q, overflow_d;

    logic [AW-1:0]  rd_idx;
    logic [AW-1:0]  wr_idx;
    logic [60:0]    head;
    logic           empty;
    logic           full;
    logic           pop;
    logic           push_accept;
    logic [PW-1:0]  count_next;
    logic [31:0]    free_next;

    assign rd_idx = rd_ptr_q[AW-1:0];
    assign wr_idx = wr_ptr_q[AW-1:0];
    assign head   = mem[rd_idx];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A flush suppresses both sides so neither a pop pulse nor an overflow can leak out.
    assign pop         = !empty && iSCHE2_READY && !iFREE_EX;
    assign push_accept = iEX_ALU2_VALID && (!full || pop) && !iFREE_EX;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        sche1_valid_d = 1'b0;
        sche1_tag_d   = sche1_tag_q;
        overflow_d    = overflow_q;
        count_next    = '0;
        free_next     = '0;
        lock_d        = 1'b0;

        if (iFREE_EX) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_accept) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d      = rd_ptr_q + 1'b1;
                sche1_valid_d = 1'b1;
                sche1_tag_d   = head[60:55];
            end
            if (iEX_ALU2_VALID && full && !pop) begin
                overflow_d = 1'b1;
            end
            count_next = wr_ptr_d - rd_ptr_d;
            free_next  = 32'(DEPTH) - 32'(count_next);
            lock_d     = (free_next <= 32'(LOCK_MARGIN));
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            sche1_valid_q <= 1'b0;
            sche1_tag_q   <= '0;
            lock_q        <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            sche1_valid_q <= sche1_valid_d;
            sche1_tag_q   <= sche1_tag_d;
            lock_q        <= lock_d;
            overflow_q    <= overflow_d;
        end
    end

    // Storage needs no reset: pointers alone decide which entries are live.
    always_ff @(posedge iCLOCK) begin
        if (push_accept) begin
            mem[wr_idx] <= iEX_ALU2_PAYLOAD;
        end
    end

    assign oSCHE2_VALID      = !empty;
    assign oSCHE2_PAYLOAD    = empty ? '0 : head;
    assign oSCHE1_VALID      = sche1_valid_q;
    assign oSCHE1_COMMIT_TAG = sche1_tag_q;
    assign oEX_ALU2_LOCK     = lock_q;
    assign oCOUNT            = wr_ptr_q - rd_ptr_q;
    assign oOVERFLOW         = overflow_q;

endmodule

// File: tb/tb_execute_port2_wb_queue.sv
// Directed bench for execute_port2_wb_queue: reset, single pass, fill/lock,
// full push+pop, overflow, flush and asynchronous mid-stream reset.
module tb_execute_port2_wb_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        free_ex;
    logic        alu_valid;
    logic [60:0] alu_payload;
    logic        sche2_ready;
    logic        lock;
    logic        sche2_valid;
    logic [60:0] sche2_payload;
    logic        sche1_valid;
    logic [5:0]  sche1_tag;
    logic [2:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    execute_port2_wb_queue #(.DEPTH(4), .LOCK_MARGIN(2)) dut (
        .iCLOCK            (clk),
        .iRESET            (rst),
        .iFREE_EX          (free_ex),
        .iEX_ALU2_VALID    (alu_valid),
        .iEX_ALU2_PAYLOAD  (alu_payload),
        .iSCHE2_READY      (sche2_ready),
        .oEX_ALU2_LOCK     (lock),
        .oSCHE2_VALID      (sche2_valid),
        .oSCHE2_PAYLOAD    (sche2_payload),
        .oSCHE1_VALID      (sche1_valid),
        .oSCHE1_COMMIT_TAG (sche1_tag),
        .oCOUNT            (count),
        .oOVERFLOW         (overflow)
    );

    function automatic logic [60:0] mk(input logic [5:0] tag, input logic [31:0] data);
        mk = {tag, 1'b1, 5'h0A, 6'h15, 1'b1, data, 5'b10101, 1'b1, 4'hC};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] tag);
        alu_valid   = 1'b1;
        alu_payload = mk(tag, {26'h0, tag});
        tick();
        alu_valid   = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        free_ex     = 1'b0;
        alu_valid   = 1'b0;
        alu_payload = '0;
        sche2_ready = 1'b0;
        tick();
        tick();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(sche2_valid), 64'd0);
        chk("rst_sche1", 64'(sche1_valid), 64'd0);
        chk("rst_tag", 64'(sche1_tag), 64'd0);
        chk("rst_lock", 64'(lock), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_payload", 64'(sche2_payload), 64'd0);
        rst = 1'b0;
        tick();

        // Single pass: push with ready high, head appears next cycle, commit one later.
        alu_valid   = 1'b1;
        alu_payload = mk(6'h05, 32'h12345678);
        sche2_ready = 1'b1;
        tick();
        alu_valid = 1'b0;
        chk("sp_valid", 64'(sche2_valid), 64'd1);
        chk("sp_payload", 64'(sche2_payload), 64'(mk(6'h05, 32'h12345678)));
        chk("sp_no_early_commit", 64'(sche1_valid), 64'd0);
        chk("sp_count1", 64'(count), 64'd1);
        tick();
        chk("sp_commit", 64'(sche1_valid), 64'd1);
        chk("sp_commit_tag", 64'(sche1_tag), 64'h05);
        chk("sp_empty", 64'(sche2_valid), 64'd0);
        chk("sp_count0", 64'(count), 64'd0);
        tick();
        chk("sp_pulse_end", 64'(sche1_valid), 64'd0);
        chk("sp_tag_hold", 64'(sche1_tag), 64'h05);

        // Fill with scheduler stalled; lock rises once two slots remain.
        sche2_ready = 1'b0;
        push(6'd1);
        chk("fill_lock_after1", 64'(lock), 64'd0);
        push(6'd2);
        chk("fill_lock_after2", 64'(lock), 64'd1);
        push(6'd3);
        push(6'd4);
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_lock", 64'(lock), 64'd1);
        chk("fill_head", 64'(sche2_payload[60:55]), 64'd1);
        chk("fill_stable_payload", 64'(sche2_payload), 64'(mk(6'd1, 32'd1)));

        // Full queue with simultaneous push and pop.
        sche2_ready = 1'b1;
        push(6'd7);
        chk("fpp_count", 64'(count), 64'd4);
        chk("fpp_no_ovf", 64'(overflow), 64'd0);
        chk("fpp_commit_tag1", 64'(sche1_tag), 64'd1);
        tick();
        chk("fpp_tag2", 64'(sche1_tag), 64'd2);
        tick();
        chk("fpp_tag3", 64'(sche1_tag), 64'd3);
        tick();
        chk("fpp_tag4", 64'(sche1_tag), 64'd4);
        tick();
        chk("fpp_tag7", 64'(sche1_tag), 64'd7);
        chk("fpp_tag7_valid", 64'(sche1_valid), 64'd1);
        chk("fpp_drained", 64'(count), 64'd0);

        // Overflow: push while full and stalled is dropped, flag sticks.
        sche2_ready = 1'b0;
        push(6'd10);
        push(6'd11);
        push(6'd12);
        push(6'd13);
        push(6'd9);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(count), 64'd4);
        chk("ovf_head", 64'(sche2_payload[60:55]), 64'd10);
        sche2_ready = 1'b1;
        tick();
        chk("ovf_tag10", 64'(sche1_tag), 64'd10);
        tick();
        chk("ovf_tag11", 64'(sche1_tag), 64'd11);
        tick();
        chk("ovf_tag12", 64'(sche1_tag), 64'd12);
        tick();
        chk("ovf_tag13", 64'(sche1_tag), 64'd13);
        chk("ovf_empty_after13", 64'(sche2_valid), 64'd0);
        tick();
        chk("ovf_no_tag9", 64'(sche1_valid), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Flush with a same-cycle push and pop request.
        sche2_ready = 1'b0;
        push(6'd20);
        push(6'd21);
        push(6'd22);
        chk("fl_count3", 64'(count), 64'd3);
        chk("fl_lock_pre", 64'(lock), 64'd1);
        free_ex     = 1'b1;
        sche2_ready = 1'b1;
        push(6'd8);
        free_ex     = 1'b0;
        sche2_ready = 1'b0;
        chk("fl_count0", 64'(count), 64'd0);
        chk("fl_valid0", 64'(sche2_valid), 64'd0);
        chk("fl_no_pulse", 64'(sche1_valid), 64'd0);
        chk("fl_lock0", 64'(lock), 64'd0);
        chk("fl_ovf_kept", 64'(overflow), 64'd1);
        sche2_ready = 1'b1;
        tick();
        chk("fl_no_tag8", 64'(sche1_valid), 64'd0);
        chk("fl_still_empty", 64'(sche2_valid), 64'd0);

        // Asynchronous reset with two entries queued.
        sche2_ready = 1'b0;
        push(6'd30);
        push(6'd31);
        chk("ar_count2", 64'(count), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_count", 64'(count), 64'd0);
        chk("ar_valid", 64'(sche2_valid), 64'd0);
        chk("ar_payload", 64'(sche2_payload), 64'd0);
        chk("ar_tag", 64'(sche1_tag), 64'd0);
        chk("ar_ovf", 64'(overflow), 64'd0);
        chk("ar_lock", 64'(lock), 64'd0);
        tick();
        rst = 1'b0;
        sche2_ready = 1'b1;
        push(6'h3F);
        chk("ar_new_valid", 64'(sche2_valid), 64'd1);
        chk("ar_new_head", 64'(sche2_payload), 64'(mk(6'h3F, 32'h3F)));
        chk("ar_new_count", 64'(count), 64'd1);
        tick();
        chk("ar_commit", 64'(sche1_valid), 64'd1);
        chk("ar_commit_tag", 64'(sche1_tag), 64'h3F);
        chk("ar_alone", 64'(sche2_valid), 64'd0);
        tick();
        chk("ar_no_more", 64'(sche1_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
